// File: rtl/dft_sse_pkg.sv
// dft_pkg: shared FSM state, twiddle ROM and built-in sample/reference tables for the DFT SSE monitor.
package dft_pkg;

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_ERR, S_ACC, S_DONE} state_t;

    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
    } cplx_t;

    localparam int TW_FRAC = 14;

    // cos/sin(2*pi*i/8) in Q1.14
    localparam logic signed [15:0] COS_ROM [8] = '{
        16'sd16384, 16'sd11585, 16'sd0, -16'sd11585, -16'sd16384, -16'sd11585, 16'sd0, 16'sd11585};
    localparam logic signed [15:0] SIN_ROM [8] = '{
        16'sd0, 16'sd11585, 16'sd16384, 16'sd11585, 16'sd0, -16'sd11585, -16'sd16384, -16'sd11585};

    localparam logic signed [15:0] COS_SET [8] = '{
        16'sd1000, 16'sd707, 16'sd0, -16'sd707, -16'sd1000, -16'sd707, 16'sd0, 16'sd707};

    function automatic logic signed [15:0] sample(input int set, input logic [2:0] n);
        return set == 1 ? 16'sd100 : set == 2 ? COS_SET[n] : (n == 3'd0 ? 16'sd1000 : 16'sd0);
    endfunction

    // All three sample sets have purely real spectra once rounded to integers
    function automatic cplx_t ref_bin(input int set, input logic [2:0] k);
        cplx_t c;
        c.im = '0;
        c.re = set == 1 ? (k == 3'd0 ? 32'sd800 : 32'sd0) :
               set == 2 ? ((k == 3'd1 || k == 3'd7) ? 32'sd4000 : 32'sd0) : 32'sd1000;
        return c;
    endfunction

endpackage

// File: rtl/dft_sse_if.sv
// dft_sse_if: result bus carrying the accumulated sum of squared errors.
interface dft_sse_if;
    logic [31:0] SSE;
    modport master (output SSE);
    modport slave  (input  SSE);
endinterface

// File: rtl/dft_sse_mac_bin.sv
// dft_mac_bin: complex MAC for one DFT bin, Q1.14 rounding and squared-error output.
module dft_mac_bin #(
    parameter int DW      = 16,
    parameter int TW_FRAC = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_mac,
    input  logic                 i_err,
    input  logic signed [DW-1:0] i_x,
    input  logic signed [15:0]   i_cos,
    input  logic signed [15:0]   i_sin,
    input  logic signed [31:0]   i_ref_re,
    input  logic signed [31:0]   i_ref_im,
    output logic [64:0]          o_sq
);
    localparam logic signed [39:0] RND = 40'sd1 <<< (TW_FRAC - 1);

    logic signed [39:0] r_re_acc, r_im_acc;
    logic signed [31:0] r_e_re, r_e_im;
    logic signed [39:0] w_re_prod, w_im_prod, w_re_rnd, w_im_rnd;
    logic signed [63:0] w_sq_re, w_sq_im;

    assign w_re_prod = 40'(i_x) * 40'(i_cos);
    assign w_im_prod = 40'(i_x) * 40'(i_sin);
    assign w_re_rnd  = (r_re_acc + RND) >>> TW_FRAC;
    assign w_im_rnd  = (r_im_acc + RND) >>> TW_FRAC;
    assign w_sq_re   = 64'(r_e_re) * 64'(r_e_re);
    assign w_sq_im   = 64'(r_e_im) * 64'(r_e_im);
    assign o_sq      = {1'b0, w_sq_re} + {1'b0, w_sq_im};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_re_acc <= '0;
            r_im_acc <= '0;
            r_e_re   <= '0;
            r_e_im   <= '0;
        end else begin
            if (i_clr) begin
                r_re_acc <= '0;
                r_im_acc <= '0;
            end else if (i_mac) begin
                r_re_acc <= r_re_acc + w_re_prod;
                r_im_acc <= r_im_acc - w_im_prod;
            end
            if (i_err) begin
                r_e_re <= 32'(w_re_rnd) - i_ref_re;
                r_e_im <= 32'(w_im_rnd) - i_ref_im;
            end
        end
    end

endmodule

// File: rtl/dft_sse.sv
// dft_sse: self-running 8-point DFT accuracy monitor; reports the saturating SSE against a reference spectrum.
module dft_sse
    import dft_pkg::*;
#(
    parameter int N          = 8,
    parameter int DW         = 16,
    parameter int TW_FRAC    = dft_pkg::TW_FRAC,
    parameter int SAMPLE_SET = 0,
    parameter int ERR_INJECT = 0
) (
    input logic        clk,
    input logic        rst,
    dft_sse_if.master  bus
);
    state_t      r_state, w_state_nx;
    logic [2:0]  r_k, r_n, w_idx;
    logic [31:0] r_sse_acc, r_sse, w_sse_nx;
    logic [64:0] w_sq;
    logic [65:0] w_sum;
    logic        w_clr, w_mac, w_err, w_last;
    cplx_t       w_ref;

    assign w_idx    = r_k * r_n;
    assign w_last   = r_k == 3'(N - 1);
    assign w_ref    = ref_bin(SAMPLE_SET, r_k);
    assign w_sum    = 66'(r_sse_acc) + 66'(w_sq);
    assign w_sse_nx = |w_sum[65:32] ? 32'hFFFF_FFFF : w_sum[31:0];
    assign bus.SSE  = r_sse;

    dft_mac_bin #(.DW(DW), .TW_FRAC(TW_FRAC)) u_mac (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_clr),
        .i_mac    (w_mac),
        .i_err    (w_err),
        .i_x      (DW'(sample(SAMPLE_SET, r_n))),
        .i_cos    (COS_ROM[w_idx]),
        .i_sin    (SIN_ROM[w_idx]),
        .i_ref_re (w_ref.re + (r_k == 3'd0 ? 32'(ERR_INJECT) : 32'sd0)),
        .i_ref_im (w_ref.im),
        .o_sq     (w_sq)
    );

    always_comb begin
        w_state_nx = r_state;
        w_clr      = 1'b0;
        w_mac      = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clr      = 1'b1;
                w_state_nx = S_MAC;
            end
            S_MAC: begin
                w_mac      = 1'b1;
                w_state_nx = r_n == 3'(N - 1) ? S_ERR : S_MAC;
            end
            S_ERR: begin
                w_err      = 1'b1;
                w_state_nx = S_ACC;
            end
            S_ACC: begin
                w_clr      = 1'b1;
                w_state_nx = w_last ? S_DONE : S_MAC;
            end
            default: w_state_nx = S_DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_n       <= '0;
            r_sse_acc <= '0;
            r_sse     <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == S_MAC) r_n <= r_n + 3'd1;
            if (r_state == S_ACC) begin
                r_n       <= '0;
                r_sse_acc <= w_sse_nx;
                r_k       <= w_last ? r_k : r_k + 3'd1;
                r_sse     <= w_last ? w_sse_nx : r_sse;
            end
        end
    end

endmodule

// File: tb/tb_dft_sse.sv
// tb_dft_sse: five DFT monitors with different sample sets / injected errors, checked by an SSE scoreboard.
module tb_dft_sse;
    localparam int NDUT = 5;
    localparam int LAT  = 81;
    localparam int          SETS  [NDUT] = '{0, 1, 2, 0, 0};
    localparam int          INJS  [NDUT] = '{0, 0, 0, 3, -70000};
    localparam logic [31:0] FINAL [NDUT] = '{32'd0, 32'd0, 32'd0, 32'd9, 32'hFFFF_FFFF};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sse [NDUT];
    logic [31:0] q [NDUT][$];
    logic [31:0] ex;
    int          checks = 0;
    int          failures = 0;
    string       phase = "init";

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dft_sse_if bus ();
        dft_sse #(.SAMPLE_SET(SETS[g]), .ERR_INJECT(INJS[g])) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign sse[g] = bus.SSE;
    end

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut%0d: SSE=%h expected %h at %0t", name, id, act, req, $time);
        end
    endtask

    // Expected SSE after edge e following release (e<=0: reset held)
    task automatic expect_edge(input int e);
        for (int i = 0; i < NDUT; i++) q[i].push_back(e >= LAT ? FINAL[i] : 32'd0);
        @(negedge clk);
    endtask

    task automatic run(input int edges);
        for (int e = 1; e <= edges; e++) expect_edge(e);
    endtask

    task automatic async_clear(input string name);
        rst = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) check(name, i, sse[i], 32'd0);
        expect_edge(0);
        expect_edge(0);
        rst = 1'b1;
    endtask

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < NDUT; i++) begin
            if (q[i].size() > 0) begin
                ex = q[i].pop_front();
                check(phase, i, sse[i], ex);
            end
        end
    end

    initial begin
        rst = 1'b0;
        phase = "reset_hold";
        expect_edge(0);
        expect_edge(0);
        rst = 1'b1;
        phase = "first_run";
        run(90);
        phase = "after_done_reset";
        async_clear("async_clear_after_done");
        phase = "second_run_partial";
        run(40);
        phase = "mid_run_reset";
        async_clear("async_clear_mid_run");
        phase = "rerun_after_abort";
        run(90);
        @(posedge clk);
        #3;
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (q[i].size() != 0) begin
                failures++;
                $display("FAIL scoreboard_drain dut%0d: %0d left, expected 0", i, q[i].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
